vproc_cfg_spec_unit: RTL and testbench

Parametrised vector configuration/CSR unit with speculative shadowing. It executes vsetvl(i) and vector-CSR operations: vtype, vl, vlenb, vstart, vxsat, vxrm and vcsr. Results are computed against the youngest speculative configuration. Architectural state updates only when the core commits the instruction; killed instructions roll back. It sits beside the decoder: speculative outputs feed decode, and architectural outputs feed the execution units.

---
 rtl/vproc_cfg_spec_unit.sv | 275 +++++++++++++++++++++++++++
 tb/tb_vproc_cfg_spec_unit.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vproc_cfg_spec_unit.sv
// vproc_cfg_spec_unit: vector configuration / CSR unit with a speculative shadow queue.
// Executes vsetvl(i) and vtype/vl/vlenb/vstart/vxsat/vxrm/vcsr operations against the
// youngest speculative configuration; architectural state changes only on commit.
// Ports:
//   clk_i, sync_rst_i             clock, synchronous active-high reset
//   req_*                         request handshake, op and operands
//   res_*                         registered result handshake (id, rd value)
//   commit_valid_i/commit_kill_i  commit or kill the oldest shadow entry
//   vxsat_set_i                   sticky saturation from committed vector ops
//   spec_*_o                      youngest speculative config (to decode)
//   vsew_o..vxsat_o               architectural state (to execution units)
//   spec_full_o                   shadow queue full
// Optional feature macro: VPROC_CFG_FRAC_LMUL_EN enables fractional LMUL.
// Encodings: vsew 0=e8 1=e16 2=e32 3=invalid; lmul 0..3=m1..m8, 4=invalid, 5=mf8 6=mf4 7=mf2.
// Ops: 0 vsetvl, 1 vtype rd, 2 vl rd, 3 vlenb rd, then {W,S,C} for vstart(4), vxsat(7),
//      vxrm(10), vcsr(13).
module vproc_cfg_spec_unit #(
  parameter int unsigned VREG_W     = 128,
  parameter int unsigned ELEN       = 32,
  parameter int unsigned SPEC_DEPTH = 4,
  parameter int unsigned ID_W       = 3,
  parameter int unsigned VL_W       = $clog2(VREG_W) + 1
) (
  input  logic            clk_i,
  input  logic            sync_rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [ID_W-1:0] req_id_i,
  input  logic [3:0]      req_op_i,
  input  logic [1:0]      req_vsew_i,
  input  logic [2:0]      req_lmul_i,
  input  logic [1:0]      req_agnostic_i,
  input  logic            req_vlmax_i,
  input  logic            req_keep_vl_i,
  input  logic [31:0]     req_xval_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [ID_W-1:0] res_id_o,
  output logic [31:0]     res_xval_o,
  input  logic            commit_valid_i,
  input  logic            commit_kill_i,
  input  logic            vxsat_set_i,
  output logic [1:0]      spec_vsew_o,
  output logic [2:0]      spec_lmul_o,
  output logic [VL_W-1:0] spec_vl_o,
  output logic            spec_vill_o,
  output logic [1:0]      vsew_o,
  output logic [2:0]      lmul_o,
  output logic [VL_W-1:0] vl_o,
  output logic            vill_o,
  output logic [VL_W-1:0] vstart_o,
  output logic [1:0]      vxrm_o,
  output logic            vxsat_o,
  output logic            spec_full_o
);

  localparam int unsigned PTR_W   = $clog2(SPEC_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ELEN_LG = $clog2(ELEN);

  localparam logic [3:0] OP_VSETVL = 4'd0, OP_VTYPE_R = 4'd1, OP_VL_R = 4'd2, OP_VLENB_R = 4'd3;
  localparam logic [3:0] OP_VSTART_W = 4'd4, OP_VSTART_S = 4'd5, OP_VSTART_C = 4'd6;
  localparam logic [3:0] OP_VXSAT_W = 4'd7, OP_VXSAT_S = 4'd8, OP_VXSAT_C = 4'd9;
  localparam logic [3:0] OP_VXRM_W = 4'd10, OP_VXRM_S = 4'd11, OP_VXRM_C = 4'd12;
  localparam logic [3:0] OP_VCSR_W = 4'd13, OP_VCSR_S = 4'd14, OP_VCSR_C = 4'd15;
  localparam logic [1:0] VSEW_INVALID = 2'd3;
  localparam logic [2:0] LMUL_INVALID = 3'd4;

  typedef struct packed {
    logic            vill;
    logic [1:0]      agn;     // {vma, vta}
    logic [1:0]      vsew;
    logic [2:0]      lmul;
    logic [VL_W-1:0] vl;
    logic [VL_W-1:0] vstart;
    logic [1:0]      vxrm;
    logic            vxsat;
  } snap_t;

  localparam snap_t RST_SNAP = '{vill: 1'b1, default: '0};

  snap_t            snap_q [SPEC_DEPTH];
  snap_t            arch_q, arch_d, base, young, new_snap, push_snap;
  logic [CNT_W-1:0] head_q, head_d, tail_q, tail_d;
  logic             res_valid_q, res_valid_d;
  logic [ID_W-1:0]  res_id_q, res_id_d;
  logic [31:0]      res_xval_q, res_xval_d, res_c;
  logic             empty, full, accept, commit_s, kill_s, ill;
  logic [PTR_W-1:0] young_idx;
  logic [3:0]       sew_lg;
  logic [VL_W-1:0]  elems, vlmax, new_vl;
  logic [31:0]      old_val, wr_val;
`ifdef VPROC_CFG_FRAC_LMUL_EN
  logic [1:0]       frac_sh;
`endif

  // Queue status; the extra pointer bit separates full from empty.
  assign empty     = (head_q == tail_q);
  assign full      = (head_q[PTR_W] != tail_q[PTR_W]) && (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]);
  assign young_idx = tail_q[PTR_W-1:0] - PTR_W'(1);
  assign young     = empty ? arch_q : snap_q[young_idx];
  assign base      = young;

  assign req_ready_o = !full && (!res_valid_q || res_ready_i);
  assign accept      = req_valid_i && req_ready_o;
  assign commit_s    = commit_valid_i && !commit_kill_i && !empty;
  assign kill_s      = commit_valid_i && commit_kill_i && !empty;

  // Execute the request against the youngest snapshot.
  always_comb begin
    new_snap = base;
    res_c    = '0;
    new_vl   = '0;
    old_val  = '0;
    wr_val   = '0;
    sew_lg   = 4'(req_vsew_i) + 4'd3;
    elems    = VL_W'(VREG_W / 8) >> req_vsew_i;
`ifdef VPROC_CFG_FRAC_LMUL_EN
    // mf2/mf4/mf8 encode as 7/6/5, so the right shift is (8 - lmul) mod 8.
    frac_sh = 2'(3'd0 - req_lmul_i);
    vlmax   = req_lmul_i[2] ? (elems >> frac_sh) : (elems << req_lmul_i[1:0]);
    ill     = (req_vsew_i == VSEW_INVALID) || (req_lmul_i == LMUL_INVALID) ||
              (32'(sew_lg) > ELEN_LG) ||
              (req_lmul_i[2] && (32'(sew_lg) + 32'(frac_sh) > ELEN_LG));
`else
    vlmax   = elems << req_lmul_i[1:0];
    ill     = (req_vsew_i == VSEW_INVALID) || req_lmul_i[2] || (32'(sew_lg) > ELEN_LG);
`endif

    case (req_op_i)
      OP_VSTART_W, OP_VSTART_S, OP_VSTART_C: old_val = 32'(base.vstart);
      OP_VXSAT_W, OP_VXSAT_S, OP_VXSAT_C:    old_val = 32'(base.vxsat);
      OP_VXRM_W, OP_VXRM_S, OP_VXRM_C:       old_val = 32'(base.vxrm);
      OP_VCSR_W, OP_VCSR_S, OP_VCSR_C:       old_val = 32'({base.vxrm, base.vxsat});
      default:                               old_val = '0;
    endcase

    case (req_op_i)
      OP_VSTART_W, OP_VXSAT_W, OP_VXRM_W, OP_VCSR_W: wr_val = req_xval_i;
      OP_VSTART_S, OP_VXSAT_S, OP_VXRM_S, OP_VCSR_S: wr_val = old_val | req_xval_i;
      default:                                       wr_val = old_val & ~req_xval_i;
    endcase

    case (req_op_i)
      OP_VSETVL: begin
        if (req_vlmax_i) begin
          new_vl = vlmax;
        end else if (req_keep_vl_i) begin
          new_vl = base.vl;
          if (base.vl > vlmax) ill = 1'b1;
        end else begin
          new_vl = (req_xval_i > 32'(vlmax)) ? vlmax : VL_W'(req_xval_i);
        end
        new_snap.vstart = '0;
        if (ill) begin
          // An illegal vtype clears the remaining vtype fields, matching the reset encoding.
          new_snap.vill = 1'b1;
          new_snap.agn  = '0;
          new_snap.vsew = '0;
          new_snap.lmul = '0;
          new_snap.vl   = '0;
        end else begin
          new_snap.vill = 1'b0;
          new_snap.agn  = req_agnostic_i;
          new_snap.vsew = req_vsew_i;
          new_snap.lmul = req_lmul_i;
          new_snap.vl   = new_vl;
        end
        res_c = 32'(new_snap.vl);
      end
      OP_VTYPE_R: res_c = {base.vill, 23'b0, base.agn, 1'b0, base.vsew, base.lmul};
      OP_VL_R:    res_c = 32'(base.vl);
      OP_VLENB_R: res_c = 32'(VREG_W / 8);
      OP_VSTART_W, OP_VSTART_S, OP_VSTART_C: begin
        new_snap.vstart = VL_W'(wr_val);
        res_c = old_val;
      end
      OP_VXSAT_W, OP_VXSAT_S, OP_VXSAT_C: begin
        new_snap.vxsat = wr_val[0];
        res_c = old_val;
      end
      OP_VXRM_W, OP_VXRM_S, OP_VXRM_C: begin
        new_snap.vxrm = wr_val[1:0];
        res_c = old_val;
      end
      default: begin
        new_snap.vxrm  = wr_val[2:1];
        new_snap.vxsat = wr_val[0];
        res_c = old_val;
      end
    endcase

    push_snap       = new_snap;
    push_snap.vxsat = new_snap.vxsat | vxsat_set_i;
  end

  // Next-state for pointers, architectural state and the result register.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    arch_d      = arch_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_xval_d  = res_xval_q;

    if (accept) begin
      res_valid_d = 1'b1;
      res_id_d    = req_id_i;
      res_xval_d  = res_c;
    end else if (res_ready_i) begin
      res_valid_d = 1'b0;
    end

    if (kill_s) begin
      head_d = tail_q;
    end else begin
      if (commit_s) begin
        arch_d = snap_q[head_q[PTR_W-1:0]];
        head_d = head_q + CNT_W'(1);
      end
      if (accept) tail_d = tail_q + CNT_W'(1);
    end
    // Committed vxsat lands first, then saturation from this cycle is ORed in.
    arch_d.vxsat = arch_d.vxsat | vxsat_set_i;
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      arch_q      <= RST_SNAP;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_xval_q  <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      arch_q      <= arch_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_xval_q  <= res_xval_d;
    end
  end

  // Snapshot storage; in-flight entries also absorb sticky saturation.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < SPEC_DEPTH; i++) begin
      if (vxsat_set_i) snap_q[i].vxsat <= 1'b1;
    end
    if (accept && !kill_s) snap_q[tail_q[PTR_W-1:0]] <= push_snap;
  end

  always @(posedge clk_i) begin
    if (!sync_rst_i && commit_valid_i) begin
      assert (!empty) else $error("commit/kill issued with empty shadow queue");
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_id_o    = res_id_q;
  assign res_xval_o  = res_xval_q;
  assign spec_vsew_o = young.vsew;
  assign spec_lmul_o = young.lmul;
  assign spec_vl_o   = young.vl;
  assign spec_vill_o = young.vill;
  assign vsew_o      = arch_q.vsew;
  assign lmul_o      = arch_q.lmul;
  assign vl_o        = arch_q.vl;
  assign vill_o      = arch_q.vill;
  assign vstart_o    = arch_q.vstart;
  assign vxrm_o      = arch_q.vxrm;
  assign vxsat_o     = arch_q.vxsat;
  assign spec_full_o = full;

endmodule

// File: tb/tb_vproc_cfg_spec_unit.sv
// Scoreboard bench for vproc_cfg_spec_unit with an integer-level reference model.
module tb_vproc_cfg_spec_unit;

  localparam int unsigned VREG_W     = 128;
  localparam int unsigned ELEN       = 32;
  localparam int unsigned SPEC_DEPTH = 4;
  localparam int unsigned ID_W       = 3;
  localparam int unsigned VL_W       = $clog2(VREG_W) + 1;

  logic            clk_i = 1'b0;
  logic            sync_rst_i, req_valid_i, req_ready_o, req_vlmax_i, req_keep_vl_i;
  logic [ID_W-1:0] req_id_i, res_id_o;
  logic [3:0]      req_op_i;
  logic [1:0]      req_vsew_i, req_agnostic_i, spec_vsew_o, vsew_o, vxrm_o;
  logic [2:0]      req_lmul_i, spec_lmul_o, lmul_o;
  logic [31:0]     req_xval_i, res_xval_o;
  logic            res_valid_o, res_ready_i, commit_valid_i, commit_kill_i, vxsat_set_i;
  logic [VL_W-1:0] spec_vl_o, vl_o, vstart_o;
  logic            spec_vill_o, vill_o, vxsat_o, spec_full_o;

  vproc_cfg_spec_unit #(.VREG_W(VREG_W), .ELEN(ELEN), .SPEC_DEPTH(SPEC_DEPTH), .ID_W(ID_W),
                        .VL_W(VL_W)) dut (
    .clk_i(clk_i), .sync_rst_i(sync_rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_id_i(req_id_i), .req_op_i(req_op_i), .req_vsew_i(req_vsew_i), .req_lmul_i(req_lmul_i),
    .req_agnostic_i(req_agnostic_i), .req_vlmax_i(req_vlmax_i), .req_keep_vl_i(req_keep_vl_i),
    .req_xval_i(req_xval_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_id_o(res_id_o), .res_xval_o(res_xval_o), .commit_valid_i(commit_valid_i),
    .commit_kill_i(commit_kill_i), .vxsat_set_i(vxsat_set_i), .spec_vsew_o(spec_vsew_o),
    .spec_lmul_o(spec_lmul_o), .spec_vl_o(spec_vl_o), .spec_vill_o(spec_vill_o),
    .vsew_o(vsew_o), .lmul_o(lmul_o), .vl_o(vl_o), .vill_o(vill_o), .vstart_o(vstart_o),
    .vxrm_o(vxrm_o), .vxsat_o(vxsat_o), .spec_full_o(spec_full_o));

  always #5 clk_i = ~clk_i;

  typedef struct {
    int vill; int vma; int vta; int vsew; int lmul; int vl; int vstart; int vxrm; int vxsat;
  } mst_t;
  typedef struct { int id; logic [31:0] x; } sb_t;

  mst_t m_arch;
  mst_t m_q[$];
  sb_t  sb_q[$];
  bit   m_res_valid;
  int   n_vec = 0, n_err = 0, id_ctr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mst_t rst_state();
    mst_t s = '{vill: 1, default: 0};
    return s;
  endfunction

  // VLMAX and legality from SEW/LMUL as plain numbers.
  function automatic void m_vlmax(input int vsew, input int lmul, output int vlmax, output bit ill);
    int sew, den;
    ill = 0; vlmax = 0;
    if (vsew == 3 || lmul == 4) begin ill = 1; return; end
    sew = 8 << vsew;
    if (sew > ELEN) ill = 1;
    if (lmul < 4) vlmax = (VREG_W / sew) * (1 << lmul);
    else begin
      den = 1 << (8 - lmul);
`ifdef VPROC_CFG_FRAC_LMUL_EN
      if (sew * den > ELEN) ill = 1;
      vlmax = VREG_W / (sew * den);
`else
      ill = 1;
`endif
    end
  endfunction

  function automatic void m_op(input mst_t b, input int op, input int vsew, input int lmul,
                               input int agn, input bit vlmx, input bit keep,
                               input logic [31:0] x, output mst_t n, output logic [31:0] r);
    int vlmax, nv, csr, kind, mask;
    longint old, nw;
    bit ill;
    n = b; r = 0;
    if (op == 0) begin
      m_vlmax(vsew, lmul, vlmax, ill);
      if (vlmx) nv = vlmax;
      else if (keep) begin nv = b.vl; if (b.vl > vlmax) ill = 1; end
      else nv = (longint'(x) > longint'(vlmax)) ? vlmax : int'(x);
      n.vstart = 0;
      if (ill) begin n.vill = 1; n.vma = 0; n.vta = 0; n.vsew = 0; n.lmul = 0; n.vl = 0; end
      else begin n.vill = 0; n.vma = agn / 2; n.vta = agn % 2; n.vsew = vsew; n.lmul = lmul; n.vl = nv; end
      r = n.vl;
    end else if (op == 1) r = (b.vill << 31) + (b.vma << 7) + (b.vta << 6) + (b.vsew << 3) + b.lmul;
    else if (op == 2) r = b.vl;
    else if (op == 3) r = VREG_W / 8;
    else begin
      csr = (op - 4) / 3; kind = (op - 4) % 3;
      case (csr)
        0: begin old = b.vstart; mask = (1 << VL_W) - 1; end
        1: begin old = b.vxsat; mask = 1; end
        2: begin old = b.vxrm; mask = 3; end
        default: begin old = b.vxrm * 2 + b.vxsat; mask = 7; end
      endcase
      if (kind == 0) nw = x;
      else if (kind == 1) nw = old | x;
      else nw = old & ~longint'(x);
      nw = nw & mask;
      case (csr)
        0: n.vstart = int'(nw);
        1: n.vxsat = int'(nw);
        2: n.vxrm = int'(nw);
        default: begin n.vxrm = int'(nw) / 2; n.vxsat = int'(nw) % 2; end
      endcase
      r = 32'(old);
    end
  endfunction

  task automatic check_state();
    mst_t y;
    y = (m_q.size() > 0) ? m_q[$] : m_arch;
    check("spec_vsew", 32'(spec_vsew_o), y.vsew);
    check("spec_lmul", 32'(spec_lmul_o), y.lmul);
    check("spec_vl", 32'(spec_vl_o), y.vl);
    check("spec_vill", 32'(spec_vill_o), y.vill);
    check("vsew", 32'(vsew_o), m_arch.vsew);
    check("lmul", 32'(lmul_o), m_arch.lmul);
    check("vl", 32'(vl_o), m_arch.vl);
    check("vill", 32'(vill_o), m_arch.vill);
    check("vstart", 32'(vstart_o), m_arch.vstart);
    check("vxrm", 32'(vxrm_o), m_arch.vxrm);
    check("vxsat", 32'(vxsat_o), m_arch.vxsat);
    check("spec_full", 32'(spec_full_o), (m_q.size() == SPEC_DEPTH) ? 1 : 0);
    check("res_valid", 32'(res_valid_o), m_res_valid);
  endtask

  // One clock: model the edge from the inputs as driven, then check state after it.
  task automatic cyc();
    bit exp_rdy, acc, killed;
    mst_t b, n;
    logic [31:0] r;
    int sz;
    @(negedge clk_i);
    if (sync_rst_i) begin
      m_arch = rst_state(); m_q.delete(); sb_q.delete(); m_res_valid = 0;
    end else begin
      exp_rdy = (m_q.size() < SPEC_DEPTH) && (!m_res_valid || res_ready_i);
      check("req_ready", 32'(req_ready_o), exp_rdy);
      acc = req_valid_i && exp_rdy;
      if (acc) begin
        b = (m_q.size() > 0) ? m_q[$] : m_arch;
        m_op(b, req_op_i, req_vsew_i, req_lmul_i, req_agnostic_i, req_vlmax_i, req_keep_vl_i,
             req_xval_i, n, r);
        sb_q.push_back('{id: req_id_i, x: r});
        m_res_valid = 1;
      end else if (res_ready_i) m_res_valid = 0;
      sz = m_q.size();
      killed = commit_valid_i && commit_kill_i && sz > 0;
      if (commit_valid_i && !commit_kill_i && sz > 0) m_arch = m_q.pop_front();
      if (killed) m_q.delete();
      else if (acc) m_q.push_back(n);
      if (vxsat_set_i) begin
        m_arch.vxsat = 1;
        foreach (m_q[i]) m_q[i].vxsat = 1;
      end
    end
    @(posedge clk_i); #1;
    check_state();
  endtask

  // Result monitor: pops the scoreboard whenever a result is consumed.
  always @(negedge clk_i) begin
    sb_t e;
    if (!sync_rst_i && res_valid_o === 1'b1 && res_ready_i === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL res_unexpected: got id %0d xval 0x%0h, expected no result", res_id_o, res_xval_o);
      end else begin
        e = sb_q.pop_front();
        check("res_id", 32'(res_id_o), e.id);
        check("res_xval", res_xval_o, e.x);
      end
    end
  end

  task automatic idle_inputs();
    req_valid_i = 0; commit_valid_i = 0; commit_kill_i = 0; vxsat_set_i = 0;
  endtask

  task automatic issue(input int op, input int vsew, input int lmul, input int agn,
                       input bit vlmx, input bit keep, input logic [31:0] x);
    req_valid_i = 1; req_op_i = 4'(op); req_vsew_i = 2'(vsew); req_lmul_i = 3'(lmul);
    req_agnostic_i = 2'(agn); req_vlmax_i = vlmx; req_keep_vl_i = keep; req_xval_i = x;
    req_id_i = ID_W'(id_ctr); id_ctr++;
    cyc();
    req_valid_i = 0;
  endtask

  task automatic commit(input bit kill);
    commit_valid_i = 1; commit_kill_i = kill;
    cyc();
    commit_valid_i = 0; commit_kill_i = 0;
  endtask

  initial begin
    int op;
    idle_inputs();
    req_id_i = '0; req_op_i = '0; req_vsew_i = '0; req_lmul_i = '0; req_agnostic_i = '0;
    req_vlmax_i = 0; req_keep_vl_i = 0; req_xval_i = '0; res_ready_i = 1;
    sync_rst_i = 1;
    cyc(); cyc();
    sync_rst_i = 0;
    check("rst_vill", 32'(vill_o), 1);
    check("rst_vl", 32'(vl_o), 0);
    check("rst_req_ready", 32'(req_ready_o), 1);

    // vsetvl e8 m1 AVL=20 -> 16, then commit
    issue(0, 0, 0, 0, 0, 0, 20);
    check("t1_res", res_xval_o, 16);
    check("t1_spec_vl", 32'(spec_vl_o), 16);
    commit(0);
    check("t1_vl", 32'(vl_o), 16);
    check("t1_vill", 32'(vill_o), 0);

    // fractional LMUL legality, then kill both
    issue(0, 2, 7, 0, 0, 0, 10);
    check("t2_e32mf2_vill", 32'(spec_vill_o), 1);
    check("t2_e32mf2_vl", 32'(spec_vl_o), 0);
    issue(0, 0, 7, 0, 0, 0, 100);
`ifdef VPROC_CFG_FRAC_LMUL_EN
    check("t2_e8mf2_vl", 32'(spec_vl_o), 8);
    check("t2_e8mf2_vill", 32'(spec_vill_o), 0);
`else
    check("t2_e8mf2_vill", 32'(spec_vill_o), 1);
`endif
    commit(1);
    check("t2_kill_spec_vl", 32'(spec_vl_o), 16);

    // fill the shadow queue
    for (int i = 0; i < 4; i++) issue(4 + (i % 3), 0, 0, 0, 0, 0, 32'(i + 3));
    check("t3_full", 32'(spec_full_o), 1);
    check("t3_ready", 32'(req_ready_o), 0);
    commit_valid_i = 1; issue(1, 0, 0, 0, 0, 0, 0); commit_valid_i = 0;
    commit_valid_i = 1; issue(2, 0, 0, 0, 0, 0, 0); commit_valid_i = 0;
    check("t3_not_full", 32'(spec_full_o), 0);
    repeat (3) commit(0);

    // speculative vsetvl killed: spec_vl reverts, vl_o holds
    issue(0, 0, 1, 0, 1, 0, 0);
    check("t4_spec_vl", 32'(spec_vl_o), 32);
    commit(1);
    check("t4_spec_vl_back", 32'(spec_vl_o), 16);
    check("t4_vl", 32'(vl_o), 16);

    // vxsat sticky against a same-cycle committed clear; vcsr write
    issue(7, 0, 0, 0, 0, 0, 1); commit(0);
    issue(9, 0, 0, 0, 0, 0, 1);
    vxsat_set_i = 1; commit(0); vxsat_set_i = 0;
    check("t5_vxsat", 32'(vxsat_o), 1);
    issue(13, 0, 0, 0, 0, 0, 5);
    check("t5_old_vcsr", res_xval_o, 1);
    commit(0);
    check("t5_vxrm", 32'(vxrm_o), 2);
    check("t5_vxsat2", 32'(vxsat_o), 1);

    // result backpressure: e16 m1 VLMAX -> 8 held
    res_ready_i = 0;
    issue(0, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t6_hold_valid", 32'(res_valid_o), 1);
      check("t6_hold_id", 32'(res_id_o), (id_ctr - 1) % 8);
      check("t6_hold_xval", res_xval_o, 8);
      check("t6_ready_low", 32'(req_ready_o), 0);
    end
    res_ready_i = 1;
    cyc(); commit(0);

    // reset with two entries pending
    issue(10, 0, 0, 0, 0, 0, 3);
    issue(0, 0, 3, 0, 1, 0, 0);
    sync_rst_i = 1; cyc(); sync_rst_i = 0;
    check("t7_full", 32'(spec_full_o), 0);
    check("t7_spec_vl", 32'(spec_vl_o), 0);
    check("t7_vill", 32'(vill_o), 1);
    check("t7_res_valid", 32'(res_valid_o), 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      idle_inputs();
      res_ready_i = ($urandom_range(0, 3) != 0);
      if (m_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        commit_valid_i = 1;
        commit_kill_i = ($urandom_range(0, 7) == 0);
      end
      vxsat_set_i = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2) != 0) begin
        op = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 15));
        req_valid_i = 1; req_op_i = 4'(op);
        req_vsew_i = 2'($urandom_range(0, 3)); req_lmul_i = 3'($urandom_range(0, 7));
        req_agnostic_i = 2'($urandom_range(0, 3));
        req_vlmax_i = ($urandom_range(0, 5) == 0);
        req_keep_vl_i = !req_vlmax_i && ($urandom_range(0, 5) == 0);
        req_xval_i = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 300);
        req_id_i = ID_W'(id_ctr); id_ctr++;
      end
      cyc();
    end

    idle_inputs();
    res_ready_i = 1;
    repeat (4) cyc();
    check("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
